// File: rtl/sra_iter_if.sv
// Request/result bundle for the iterative arithmetic right-shift unit.
// The requester drives start/in1/in2 and observes out/busy/done.
// The shifter takes the opposite direction on every signal.
interface sra_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output in1,
        output in2,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  in1,
        input  in2,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/sra_iter.sv
// Iterative arithmetic right shift: shifts one bit per clock and fills vacated bits with the sign.
// Latency: for shift amount n, done pulses n+1 cycles after the accepting edge (1..WIDTH cycles).
// Backpressure: start is ignored while busy is high; the caller stalls on busy, with no queueing.
module sra_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic      clk,
    input  logic      rst,
    sra_iter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] out_q;
    logic             done_q;

    // Only the low SHW bits of the amount matter; the rest are deliberately dropped.
    logic unused_in2_hi;
    assign unused_in2_hi = ^bus.in2[WIDTH-1:SHW];

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = (state == SHIFT);

    // Control FSM and datapath: capture on start, shift while cnt is nonzero, then publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= bus.in1;
                        cnt   <= bus.in2[SHW-1:0];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        // The top bit is replicated, so the original sign fills every vacated position.
                        acc <= {acc[WIDTH-1], acc[WIDTH-1:1]};
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_q  <= acc;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sra_iter.sv
// Directed bench for sra_iter: a vector table of single operations plus hand sequences
// for ignore-while-busy, back-to-back issue and mid-operation reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sra_iter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sra_iter_if #(.WIDTH(32)) bus ();

    sra_iter #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] exp_out;
        int          amt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse.
    // Sample k counts falling edges after the accepting rising edge; done must appear at k = amt+2.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input int amt, input string name);
        int busy_cnt;
        int k;
        bit got;
        busy_cnt = 0;
        k        = 1;
        got      = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in1   = 32'hDEADBEEF;
        bus.in2   = 32'h0000001F;
        while (!got && k < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk({name, " done seen"}, 32'(got), 32'd1);
        chk({name, " done cycle"}, 32'(k), 32'(amt + 2));
        chk({name, " busy cycles"}, 32'(busy_cnt), 32'(amt + 1));
        chk({name, " out"}, bus.out, exp_out);
        chk({name, " busy low at done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'(bus.done), 32'd0);
        chk({name, " out held"}, bus.out, exp_out);
    endtask

    initial begin
        logic [31:0] prev;
        int          ndone;
        int          done_k;
        int          busy_ok;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;

        vecs[0] = '{32'h80000010, 32'h00000004, 32'hF8000001, 4};
        vecs[1] = '{32'h7FFFFFF0, 32'h00000024, 32'h07FFFFFF, 4};
        vecs[2] = '{32'h12345678, 32'h00000020, 32'h12345678, 0};
        vecs[3] = '{32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 31};
        vecs[4] = '{32'h40000000, 32'h0000001F, 32'h00000000, 31};
        vecs[5] = '{32'hF0000000, 32'h00000008, 32'hFFF00000, 8};
        vecs[6] = '{32'h00000100, 32'h00000001, 32'h00000080, 1};
        vecs[7] = '{32'hC0000001, 32'hFFFFFFE1, 32'hE0000000, 1};

        // Reset values, asynchronous: visible before any clock edge.
        #1;
        chk("reset out", bus.out, 32'h0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].in1, vecs[i].in2, vecs[i].exp_out, vecs[i].amt,
                   $sformatf("vec%0d", i));
        end

        // Ignore while busy: second start 3 cycles in must neither restart nor touch out.
        prev   = bus.out;
        ndone  = 0;
        done_k = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 32'hF0000000;
        bus.in2   = 32'h00000008;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (bus.done) begin
                ndone++;
                done_k = k;
            end
            if (k == 4) chk("busy-ignore out unchanged", bus.out, prev);
            if (k == 3) begin
                bus.start = 1'b1;
                bus.in1   = 32'h12345678;
                bus.in2   = 32'h00000002;
            end else begin
                bus.start = 1'b0;
            end
            if (k < 25) @(negedge clk);
        end
        chk("busy-ignore done count", 32'(ndone), 32'd1);
        chk("busy-ignore done cycle", 32'(done_k), 32'd10);
        chk("busy-ignore out", bus.out, 32'hFFF00000);

        // Back-to-back: new start presented during the done cycle of the previous op.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 32'h80000010;
        bus.in2   = 32'h00000004;
        @(negedge clk);
        bus.start = 1'b0;
        ndone     = 0;
        done_k    = 0;
        busy_ok   = 0;
        for (int k = 1; k <= 15; k++) begin
            if (bus.done) begin
                ndone++;
                done_k = k;
            end
            if (k == 6) chk("b2b first out", bus.out, 32'hF8000001);
            if ((k == 7 || k == 8) && bus.busy) busy_ok++;
            if (k == 9) chk("b2b second out", bus.out, 32'h00000080);
            if (bus.done && k == 6) begin
                bus.start = 1'b1;
                bus.in1   = 32'h00000100;
                bus.in2   = 32'h00000001;
            end else begin
                bus.start = 1'b0;
            end
            if (k < 15) @(negedge clk);
        end
        chk("b2b done count", 32'(ndone), 32'd2);
        chk("b2b second done cycle", 32'(done_k), 32'd9);
        chk("b2b busy no gap", 32'(busy_ok), 32'd2);

        // Reset mid-operation: outputs clear at once, no done afterwards, then a fresh op works.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in1   = 32'h80000000;
        bus.in2   = 32'h00000014;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k < 7; k++) @(negedge clk);
        chk("midop busy before rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midop rst out", bus.out, 32'h0);
        chk("midop rst busy", 32'(bus.busy), 32'd0);
        chk("midop rst done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midop no done after rst", 32'(ndone), 32'd0);
        chk("midop out stays 0", bus.out, 32'h0);
        run_op(32'h80000000, 32'h00000014, 32'hFFFFF800, 20, "post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
